// File: rtl/stopwatch_module.sv
// Centisecond stopwatch: 100 Hz prescaler driving a BCD mm:ss.cc cascade that wraps at 59:59.99.
// Counts only while pause=1; clear zeroes the prescaler and digits, and rst overrides everything.
module stopwatch_module #(
    parameter int DIV = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       wrap
);

    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_n;
    logic [7:0]       cs_n;
    logic [7:0]       sec_n;
    logic [7:0]       min_n;
    logic             wrap_n;
    logic             tick;
    logic [6:0]       carry;

    // One BCD digit: advance when enabled, returning to zero after reaching its top value.
    function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] top, input logic en);
        if (!en) begin
            return d;
        end else if (d >= top) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    always_comb begin
        tick   = pause && (pre == PRE_LAST);
        carry  = '0;
        pre_n  = pre;
        cs_n   = cs_bcd;
        sec_n  = sec_bcd;
        min_n  = min_bcd;
        wrap_n = 1'b0;

        // The whole ripple resolves in one edge, so no intermediate digit values are ever visible.
        carry[0]     = tick;
        cs_n[3:0]    = bump(cs_bcd[3:0],  4'd9, carry[0]);
        carry[1]     = carry[0] && (cs_bcd[3:0]  >= 4'd9);
        cs_n[7:4]    = bump(cs_bcd[7:4],  4'd9, carry[1]);
        carry[2]     = carry[1] && (cs_bcd[7:4]  >= 4'd9);
        sec_n[3:0]   = bump(sec_bcd[3:0], 4'd9, carry[2]);
        carry[3]     = carry[2] && (sec_bcd[3:0] >= 4'd9);
        sec_n[7:4]   = bump(sec_bcd[7:4], 4'd5, carry[3]);
        carry[4]     = carry[3] && (sec_bcd[7:4] >= 4'd5);
        min_n[3:0]   = bump(min_bcd[3:0], 4'd9, carry[4]);
        carry[5]     = carry[4] && (min_bcd[3:0] >= 4'd9);
        min_n[7:4]   = bump(min_bcd[7:4], 4'd5, carry[5]);
        carry[6]     = carry[5] && (min_bcd[7:4] >= 4'd5);
        wrap_n       = carry[6];

        if (pause) begin
            pre_n = tick ? '0 : pre + PRE_W'(1);
        end

        // Clear beats any tick or wrap in the same cycle.
        if (clear) begin
            pre_n  = '0;
            cs_n   = 8'h00;
            sec_n  = 8'h00;
            min_n  = 8'h00;
            wrap_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre     <= '0;
            cs_bcd  <= 8'h00;
            sec_bcd <= 8'h00;
            min_bcd <= 8'h00;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            pre     <= pre_n;
            cs_bcd  <= cs_n;
            sec_bcd <= sec_n;
            min_bcd <= min_n;
            running <= pause;
            wrap    <= wrap_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_module.sv
// Bench for stopwatch_module: a driver issues per-cycle controls and queues the expected outputs.
// A negedge monitor compares those expectations against the registered DUT outputs after every edge.
module tb_stopwatch_module;

    localparam int DIV   = 4;
    localparam int SPAN  = 360000;  // centiseconds in one full 60-minute lap

    logic       clk = 1'b0;
    logic       rst;
    logic       pause;
    logic       clear;
    logic [7:0] cs_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       running;
    logic       wrap;

    always #5 clk = ~clk;

    stopwatch_module #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .pause   (pause),
        .clear   (clear),
        .cs_bcd  (cs_bcd),
        .sec_bcd (sec_bcd),
        .min_bcd (min_bcd),
        .running (running),
        .wrap    (wrap)
    );

    // Expected vector layout: {wrap, running, min_bcd, sec_bcd, cs_bcd}
    logic [25:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference model: elapsed time as a plain centisecond count plus a cycle count within the tick.
    int   m_time = 0;
    int   m_pre  = 0;
    logic m_run  = 1'b0;
    logic m_wrap = 1'b0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [25:0] model_outputs();
        int cs;
        int sec;
        int mins;
        cs   = m_time % 100;
        sec  = (m_time / 100) % 60;
        mins = m_time / 6000;
        return {m_wrap, m_run, to_bcd(mins), to_bcd(sec), to_bcd(cs)};
    endfunction

    task automatic model_edge(input logic r, input logic p, input logic c);
        if (r) begin
            m_time = 0;
            m_pre  = 0;
            m_run  = 1'b0;
            m_wrap = 1'b0;
        end else begin
            m_run  = p;
            m_wrap = 1'b0;
            if (c) begin
                m_time = 0;
                m_pre  = 0;
            end else if (p) begin
                m_pre = m_pre + 1;
                if (m_pre == DIV) begin
                    m_pre  = 0;
                    m_time = m_time + 1;
                    if (m_time == SPAN) begin
                        m_time = 0;
                        m_wrap = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic p, input logic c);
        @(negedge clk);
        #1;
        rst   = r;
        pause = p;
        clear = c;
        model_edge(r, p, c);
        exp_q.push_back(model_outputs());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Jump the digits to a chosen time while paused, instead of counting there cycle by cycle.
    task automatic preload(input logic [7:0] m, input logic [7:0] s, input logic [7:0] c, input int t);
        @(negedge clk);
        #1;
        rst   = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        force dut.min_bcd = m;
        force dut.sec_bcd = s;
        force dut.cs_bcd  = c;
        m_time = t;
        model_edge(1'b0, 1'b0, 1'b0);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        release dut.min_bcd;
        release dut.sec_bcd;
        release dut.cs_bcd;
    endtask

    always @(negedge clk) begin
        logic [25:0] exp_v;
        logic [25:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {wrap, running, min_bcd, sec_bcd, cs_bcd};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs @%0t: got wrap=%0b run=%0b %h:%h.%h, expected wrap=%0b run=%0b %h:%h.%h",
                         $time, act_v[25], act_v[24], act_v[23:16], act_v[15:8], act_v[7:0],
                         exp_v[25], exp_v[24], exp_v[23:16], exp_v[15:8], exp_v[7:0]);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        pause = 1'b0;
        clear = 1'b0;

        // Reset state, with the other controls toggling underneath it.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);

        // Free run from reset: 01 after 4 edges, 02 after 8, 10 after 40.
        run(44);

        // Partial prescaler survives a pause.
        step(1'b0, 1'b0, 1'b1);
        run(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        run(6);

        // Clear landing on the tick edge at 00:00.99.
        step(1'b0, 1'b1, 1'b1);
        run(99 * DIV + DIV - 1);
        step(1'b0, 1'b1, 1'b1);
        run(DIV + 2);

        // Held clear keeps everything at zero; counting restarts from a fresh prescaler.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        run(DIV + 1);

        // Minute carry: through 00:59.99 into 01:00.00.
        step(1'b0, 1'b1, 1'b1);
        run(6000 * DIV + 2 * DIV);

        // Full lap wrap from 59:59.99.
        step(1'b0, 1'b0, 1'b1);
        preload(8'h59, 8'h59, 8'h99, SPAN - 1);
        run(3 * DIV);

        // Digit-boundary carries at other positions.
        preload(8'h09, 8'h59, 8'h98, 9 * 6000 + 5998);
        run(3 * DIV);

        // Reset mid-count at 00:12.34 with pause and clear both high.
        preload(8'h00, 8'h12, 8'h34, 1234);
        run(DIV + 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        run(DIV);

        // Randomised control mix.
        for (int i = 0; i < 600; i++) begin
            step(1'b0 | ($urandom_range(0, 99) == 0),
                 1'b0 | ($urandom_range(0, 3) != 0),
                 1'b0 | ($urandom_range(0, 24) == 0));
        end

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
